efuse_seq_ctrl: RTL

- Parametrised successor eFuse sequencer. Sits between reg_ctrl/PMU and the eFuse read/write macro drivers.
- Performs a full-array autoload into an internal shadow on PMU start.
- Arbitrates manual read, password-protected write, and a new full-array blank-check mode.
- Adds per-access timeout and sticky error reporting.

---
 rtl/efuse_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/efuse_seq_ctrl.sv
// eFuse sequencer: autoloads the fuse array into a shadow, then arbitrates manual
// read, password-gated write and full-array blank check with per-access timeout.
module efuse_seq_ctrl #(
  parameter int          EFUSE_BITS = 256,
  parameter int          NR         = 64,
  parameter int          NW         = 64,
  parameter logic [15:0] PASSWORD   = 16'hA5C3,
  parameter int          TO_CYC     = 1023,
  localparam int         RS         = $clog2(EFUSE_BITS / NR),
  localparam int         WS         = $clog2(EFUSE_BITS / NW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmu_efuse_start,
  input  logic [1:0]            rg_efuse_mode,
  input  logic                  rg_efuse_start,
  input  logic [RS-1:0]         rg_efuse_read_sel,
  input  logic [WS-1:0]         rg_efuse_write_sel,
  input  logic [15:0]           rg_efuse_password,
  input  logic [NW-1:0]         rg_efuse_wdata,
  output logic [NR-1:0]         rg_efuse_rdata,
  output logic                  rg_efuse_read_done,
  output logic                  rg_efuse_write_done,
  output logic                  rg_efuse_no_blank,
  output logic [2:0]            rg_efuse_err,
  input  logic                  rg_efuse_err_clr,
  output logic [EFUSE_BITS-1:0] efuse_shadow,
  output logic                  efuse_autoload_done,
  output logic                  efuse_autoload_vld,
  output logic                  efuse_busy,
  output logic                  read_start,
  output logic [RS-1:0]         read_sel,
  input  logic                  read_done,
  input  logic [NR-1:0]         read_data,
  output logic                  write_start,
  output logic [WS-1:0]         write_sel,
  output logic [NW-1:0]         write_data,
  input  logic                  write_done
);

  localparam int            TW      = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
  localparam logic [RS-1:0] LAST_RD = RS'(EFUSE_BITS / NR - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, AL_RD, AL_WAIT, RD_WAIT, WR_WAIT, BC_RD, BC_WAIT
  } state_t;

  state_t        state, state_d;
  logic          read_done_q, write_done_q;
  logic          rd_pos, wr_pos;
  logic [RS-1:0] cnt;
  logic          acc;
  logic [TW-1:0] to_cnt;
  logic          in_wait, to_hit;

  logic          rd_start_d, rd_sel_manual, wr_start_d;
  logic          cnt_clr, cnt_inc, acc_upd, shadow_we;
  logic          scan_fin, al_fin, rd_fin, wr_fin;
  logic          rd_done_clr, wr_done_clr, to_clr;
  logic [2:0]    err_set;

  assign rd_pos  = read_done & ~read_done_q;
  assign wr_pos  = write_done & ~write_done_q;
  assign in_wait = (state == AL_WAIT) || (state == BC_WAIT) ||
                   (state == RD_WAIT) || (state == WR_WAIT);
  assign to_hit  = in_wait && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state;
    rd_start_d    = 1'b0;
    rd_sel_manual = 1'b0;
    wr_start_d    = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    acc_upd       = 1'b0;
    shadow_we     = 1'b0;
    scan_fin      = 1'b0;
    al_fin        = 1'b0;
    rd_fin        = 1'b0;
    wr_fin        = 1'b0;
    rd_done_clr   = 1'b0;
    wr_done_clr   = 1'b0;
    to_clr        = 1'b0;
    err_set       = 3'b000;

    if (pmu_efuse_start) begin
      cnt_clr = 1'b1;
      state_d = AL_RD;
    end else begin
      case (state)
        IDLE: begin
          if (rg_efuse_start) begin
            if (!efuse_autoload_done) begin
              err_set[2] = 1'b1;
            end else begin
              case (rg_efuse_mode)
                2'd0: begin
                  rd_start_d    = 1'b1;
                  rd_sel_manual = 1'b1;
                  rd_done_clr   = 1'b1;
                  to_clr        = 1'b1;
                  state_d       = RD_WAIT;
                end
                2'd1: begin
                  if (rg_efuse_password == PASSWORD) begin
                    wr_start_d  = 1'b1;
                    wr_done_clr = 1'b1;
                    to_clr      = 1'b1;
                    state_d     = WR_WAIT;
                  end else begin
                    err_set[0] = 1'b1;
                  end
                end
                2'd2: begin
                  cnt_clr = 1'b1;
                  state_d = BC_RD;
                end
                default: ;
              endcase
            end
          end
        end
        AL_RD, BC_RD: begin
          rd_start_d = 1'b1;
          to_clr     = 1'b1;
          state_d    = (state == AL_RD) ? AL_WAIT : BC_WAIT;
        end
        AL_WAIT, BC_WAIT: begin
          if (rd_pos) begin
            acc_upd   = 1'b1;
            shadow_we = (state == AL_WAIT);
            if (cnt == LAST_RD) begin
              scan_fin = 1'b1;
              al_fin   = (state == AL_WAIT);
              state_d  = IDLE;
            end else begin
              cnt_inc = 1'b1;
              state_d = (state == AL_WAIT) ? AL_RD : BC_RD;
            end
          end else if (to_hit) begin
            err_set[1] = 1'b1;
            state_d    = IDLE;
          end
        end
        RD_WAIT: begin
          if (rd_pos) begin
            rd_fin  = 1'b1;
            state_d = IDLE;
          end else if (to_hit) begin
            err_set[1] = 1'b1;
            state_d    = IDLE;
          end
        end
        WR_WAIT: begin
          if (wr_pos) begin
            wr_fin  = 1'b1;
            state_d = IDLE;
          end else if (to_hit) begin
            err_set[1] = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the shadow array is reset along with everything else because consumers
  // may read it before any autoload has run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_done_q         <= 1'b0;
      write_done_q        <= 1'b0;
      cnt                 <= '0;
      acc                 <= 1'b0;
      to_cnt              <= '0;
      read_start          <= 1'b0;
      read_sel            <= '0;
      write_start         <= 1'b0;
      write_sel           <= '0;
      write_data          <= '0;
      rg_efuse_rdata      <= '0;
      rg_efuse_read_done  <= 1'b0;
      rg_efuse_write_done <= 1'b0;
      rg_efuse_no_blank   <= 1'b0;
      rg_efuse_err        <= 3'b000;
      efuse_shadow        <= '0;
      efuse_autoload_done <= 1'b0;
      efuse_autoload_vld  <= 1'b0;
      efuse_busy          <= 1'b0;
    end else begin
      read_done_q  <= read_done;
      write_done_q <= write_done;
      efuse_busy   <= (state != IDLE);

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + RS'(1);

      if (cnt_clr)      acc <= 1'b0;
      else if (acc_upd) acc <= acc | (read_data != '0);

      if (to_clr)       to_cnt <= '0;
      else if (in_wait) to_cnt <= to_cnt + TW'(1);

      read_start <= rd_start_d;
      if (rd_start_d) read_sel <= rd_sel_manual ? rg_efuse_read_sel : cnt;

      write_start <= wr_start_d;
      if (wr_start_d) begin
        write_sel  <= rg_efuse_write_sel;
        write_data <= rg_efuse_wdata;
      end

      if (shadow_we) efuse_shadow[cnt*NR +: NR] <= read_data;
      if (scan_fin)  rg_efuse_no_blank <= acc | (read_data != '0);

      efuse_autoload_vld <= al_fin;
      if (al_fin) efuse_autoload_done <= 1'b1;

      if (rd_fin) begin
        rg_efuse_rdata     <= read_data;
        rg_efuse_read_done <= 1'b1;
      end else if (rd_done_clr) begin
        rg_efuse_read_done <= 1'b0;
      end

      if (wr_fin)           rg_efuse_write_done <= 1'b1;
      else if (wr_done_clr) rg_efuse_write_done <= 1'b0;

      // A flag raised this cycle survives a simultaneous clear.
      rg_efuse_err <= (rg_efuse_err_clr ? 3'b000 : rg_efuse_err) | err_set;
    end
  end

endmodule
